// File: rtl/ctrl_unit_pipelined_pkg.sv
// Shared opcode/ALU encodings, E-stage control bundle and halt FSM state type
// for the pipelined decode control unit.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_AND  = 6'd6;
  localparam logic [5:0] ALU_OR   = 6'd7;
  localparam logic [5:0] ALU_XOR  = 6'd8;
  localparam logic [5:0] ALU_SLT  = 6'd9;
  localparam logic [5:0] ALU_LUI  = 6'd15;

  localparam logic [4:0] LUI_SHAMT = 5'd16;

  // All-zero value of this struct is the pipeline bubble.
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dest;
    logic [5:0] alucon;
    logic [4:0] shamt;
    logic       valid;
  } ctrl_bundle_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} halt_state_t;

endpackage

// File: rtl/ctrl_unit_pipelined_if.sv
// D-stage instruction inputs, E-stage control outputs and halt/status signals
// of the control unit, bundled for connection to the surrounding pipeline.
interface ctrl_unit_pipelined_if #(
  parameter int unsigned ALUCON_W = 6
);

  logic                instr_valid_d;
  logic [5:0]          op_code;
  logic [5:0]          funct;
  logic [4:0]          shamt_in;
  logic                stall_e;
  logic                flush_e;
  logic                branch_d;
  logic                branch_ne_d;
  logic                illegal_d;
  logic                reg_write_e;
  logic                mem_to_reg_e;
  logic                mem_write_e;
  logic                alu_src_e;
  logic                reg_dest_e;
  logic [ALUCON_W-1:0] alucon_e;
  logic [4:0]          shamt_e;
  logic                valid_e;
  logic                fetch_stop;
  logic                halted;
  logic [7:0]          illegal_cnt;

  modport master (
    output instr_valid_d, op_code, funct, shamt_in, stall_e, flush_e,
    input  branch_d, branch_ne_d, illegal_d,
    input  reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, reg_dest_e,
    input  alucon_e, shamt_e, valid_e, fetch_stop, halted, illegal_cnt
  );

  modport slave (
    input  instr_valid_d, op_code, funct, shamt_in, stall_e, flush_e,
    output branch_d, branch_ne_d, illegal_d,
    output reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, reg_dest_e,
    output alucon_e, shamt_e, valid_e, fetch_stop, halted, illegal_cnt
  );

endinterface

// File: rtl/ctrl_unit_pipelined_decode.sv
// Pure combinational MIPS op/funct decode into the E-stage control bundle,
// plus D-stage branch, illegal-opcode and halt-request flags.
module ctrl_decode_comb
  import ctrl_pkg::*;
#(
  parameter logic [5:0] HALT_OP    = 6'h3F,
  parameter bit         ENABLE_BNE = 1'b1,
  parameter bit         ENABLE_LUI = 1'b1
) (
  input  logic         instr_valid,
  input  logic [5:0]   op_code,
  input  logic [5:0]   funct,
  input  logic [4:0]   shamt_in,
  output ctrl_bundle_t bundle,
  output logic         branch,
  output logic         branch_ne,
  output logic         illegal,
  output logic         halt_req
);

  always_comb begin
    bundle    = '0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    illegal   = 1'b0;
    halt_req  = 1'b0;
    if (instr_valid) begin
      // HALT_OP is checked first so it is never classed as illegal.
      if (op_code == HALT_OP) begin
        halt_req = 1'b1;
      end else begin
        unique case (op_code)
          OP_RTYPE: begin
            if (funct != '0) begin
              bundle.alucon    = funct;
              bundle.reg_write = 1'b1;
              bundle.reg_dest  = 1'b1;
              bundle.shamt     = shamt_in;
              bundle.valid     = 1'b1;
            end
          end
          OP_BEQ: branch = 1'b1;
          OP_BNE: begin
            if (ENABLE_BNE) branch_ne = 1'b1;
            else            illegal   = 1'b1;
          end
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
            unique case (op_code)
              OP_SLTI: bundle.alucon = ALU_SLT;
              OP_ANDI: bundle.alucon = ALU_AND;
              OP_ORI:  bundle.alucon = ALU_OR;
              OP_XORI: bundle.alucon = ALU_XOR;
              default: bundle.alucon = ALU_ADD;
            endcase
            bundle.reg_write = 1'b1;
            bundle.alu_src   = 1'b1;
            bundle.valid     = 1'b1;
          end
          OP_LUI: begin
            if (ENABLE_LUI) begin
              bundle.alucon    = ALU_LUI;
              bundle.reg_write = 1'b1;
              bundle.alu_src   = 1'b1;
              bundle.shamt     = LUI_SHAMT;
              bundle.valid     = 1'b1;
            end else begin
              illegal = 1'b1;
            end
          end
          OP_LW: begin
            bundle.alucon     = ALU_ADD;
            bundle.reg_write  = 1'b1;
            bundle.mem_to_reg = 1'b1;
            bundle.alu_src    = 1'b1;
            bundle.valid      = 1'b1;
          end
          OP_SW: begin
            bundle.alucon    = ALU_ADD;
            bundle.mem_write = 1'b1;
            bundle.alu_src   = 1'b1;
            bundle.valid     = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
    end
  end

endmodule

// File: rtl/ctrl_unit_pipelined.sv
// Decode-stage control unit: registered ID/EX control bundle with stall/flush,
// halt FSM that drains the pipeline, and saturating illegal-opcode counter.
module ctrl_unit_pipelined
  import ctrl_pkg::*;
#(
  parameter int unsigned ALUCON_W     = 6,
  parameter logic [5:0]  HALT_OP      = 6'h3F,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter bit          ENABLE_BNE   = 1'b1,
  parameter bit          ENABLE_LUI   = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  ctrl_unit_pipelined_if.slave bus
);

  ctrl_bundle_t dec_bundle;
  ctrl_bundle_t e_q;
  logic         dec_branch;
  logic         dec_branch_ne;
  logic         dec_illegal;
  logic         dec_halt;
  halt_state_t  state_q, state_d;
  logic [3:0]   drain_q, drain_d;
  logic [7:0]   illegal_cnt_q;
  logic         run;
  logic         accept;

  ctrl_decode_comb #(
    .HALT_OP   (HALT_OP),
    .ENABLE_BNE(ENABLE_BNE),
    .ENABLE_LUI(ENABLE_LUI)
  ) u_decode (
    .instr_valid(bus.instr_valid_d),
    .op_code    (bus.op_code),
    .funct      (bus.funct),
    .shamt_in   (bus.shamt_in),
    .bundle     (dec_bundle),
    .branch     (dec_branch),
    .branch_ne  (dec_branch_ne),
    .illegal    (dec_illegal),
    .halt_req   (dec_halt)
  );

  assign run    = (state_q == RUN);
  assign accept = bus.instr_valid_d & ~bus.stall_e & ~bus.flush_e & run;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      RUN: begin
        if (accept && dec_halt) begin
          state_d = DRAIN;
          drain_d = 4'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        if (drain_q <= 4'd1) begin
          state_d = HALTED;
          drain_d = '0;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Flush beats stall; outside RUN the register only ever takes bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush_e) begin
      e_q <= '0;
    end else if (!bus.stall_e) begin
      e_q <= run ? dec_bundle : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_cnt_q <= '0;
    end else if (accept && dec_illegal && illegal_cnt_q != 8'hFF) begin
      illegal_cnt_q <= illegal_cnt_q + 8'd1;
    end
  end

  assign bus.branch_d     = run & dec_branch;
  assign bus.branch_ne_d  = run & dec_branch_ne;
  assign bus.illegal_d    = run & dec_illegal;
  assign bus.reg_write_e  = e_q.reg_write;
  assign bus.mem_to_reg_e = e_q.mem_to_reg;
  assign bus.mem_write_e  = e_q.mem_write;
  assign bus.alu_src_e    = e_q.alu_src;
  assign bus.reg_dest_e   = e_q.reg_dest;
  assign bus.alucon_e     = ALUCON_W'(e_q.alucon);
  assign bus.shamt_e      = e_q.shamt;
  assign bus.valid_e      = e_q.valid;
  assign bus.fetch_stop   = (state_q != RUN);
  assign bus.halted       = (state_q == HALTED);
  assign bus.illegal_cnt  = illegal_cnt_q;

endmodule

// File: tb/tb_ctrl_unit_pipelined.sv
// Directed plus randomized bench for ctrl_unit_pipelined against a table-driven
// reference model of decode, E-stage register, halt timing and illegal count.
module tb_ctrl_unit_pipelined;

  localparam int HALT = 62;
  localparam int DRAIN = 4;

  typedef struct {
    bit rw, m2r, mw, src, rdst;
    int alucon, shamt;
    bit valid, br, bne, ill, halt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ctrl_unit_pipelined_if #(.ALUCON_W(6)) bus ();

  ctrl_unit_pipelined #(
    .ALUCON_W    (6),
    .HALT_OP     (6'h3E),
    .DRAIN_CYCLES(DRAIN),
    .ENABLE_BNE  (1'b0),
    .ENABLE_LUI  (1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   m_acc = 0;
  bit   m_stop = 1'b0;
  int   m_cnt = 0;
  exp_t m_e = '{default: 0};

  function automatic exp_t ref_dec(bit v, int op, int f, int sh);
    exp_t e = '{default: 0};
    if (!v) return e;
    if (op == HALT) e.halt = 1'b1;
    else if (op == 0) begin
      if (f != 0) begin
        e.rw = 1; e.rdst = 1; e.alucon = f; e.shamt = sh; e.valid = 1;
      end
    end
    else if (op == 4) e.br = 1'b1;
    else if (op == 8 || op == 10 || op == 12 || op == 13 || op == 14) begin
      e.rw = 1; e.src = 1; e.valid = 1;
      e.alucon = (op == 10) ? 9 : (op == 12) ? 6 : (op == 13) ? 7 : (op == 14) ? 8 : 0;
    end
    else if (op == 15) begin
      e.rw = 1; e.src = 1; e.alucon = 15; e.shamt = 16; e.valid = 1;
    end
    else if (op == 35) begin
      e.rw = 1; e.m2r = 1; e.src = 1; e.valid = 1;
    end
    else if (op == 43) begin
      e.mw = 1; e.src = 1; e.valid = 1;
    end
    else e.ill = 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] pack_e(exp_t e);
    logic [5:0] a = 6'(e.alucon);
    logic [4:0] s = 5'(e.shamt);
    return {15'd0, e.rw, e.m2r, e.mw, e.src, e.rdst, a, s, e.valid};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  task automatic set_in(bit v, int op, int f, int sh, bit st, bit fl);
    bus.instr_valid_d = v;
    bus.op_code       = 6'(op);
    bus.funct         = 6'(f);
    bus.shamt_in      = 5'(sh);
    bus.stall_e       = st;
    bus.flush_e       = fl;
  endtask

  task automatic tick();
    exp_t d;
    bit   run;
    bit   acc;
    #1;
    run = !m_stop;
    d = ref_dec(bus.instr_valid_d, int'(bus.op_code), int'(bus.funct), int'(bus.shamt_in));
    chk("comb_d", {29'd0, bus.branch_d, bus.branch_ne_d, bus.illegal_d},
        {29'd0, run & d.br, run & d.bne, run & d.ill});
    acc = run && bus.instr_valid_d && !bus.stall_e && !bus.flush_e;
    if (!rst_n) begin
      m_e = '{default: 0}; m_stop = 0; m_cnt = 0;
    end else begin
      if (bus.flush_e) m_e = '{default: 0};
      else if (!bus.stall_e) m_e = run ? d : '{default: 0};
      if (acc && d.halt) begin m_stop = 1; m_acc = cyc; end
      if (acc && d.ill && m_cnt < 255) m_cnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("e_bundle", {15'd0, bus.reg_write_e, bus.mem_to_reg_e, bus.mem_write_e, bus.alu_src_e,
                     bus.reg_dest_e, bus.alucon_e, bus.shamt_e, bus.valid_e}, pack_e(m_e));
    chk("status", {22'd0, bus.fetch_stop, bus.halted, bus.illegal_cnt},
        {22'd0, m_stop, m_stop && (cyc - m_acc >= DRAIN + 1), 8'(m_cnt)});
  endtask

  initial begin
    int legal_ops[11] = '{0, 4, 5, 8, 10, 12, 13, 14, 15, 35, 43};
    int op;
    set_in(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick(); tick();
    chk("reset_valid_e", {31'd0, bus.valid_e}, 32'd0);
    rst_n = 1'b1;

    // add
    set_in(1, 0, 32, 0, 0, 0); tick();
    chk("add_alucon", {26'd0, bus.alucon_e}, 32'd32);
    chk("add_valid", {31'd0, bus.valid_e}, 32'd1);

    // lw then stall twice with a different instruction present
    set_in(1, 35, 0, 0, 0, 0); tick();
    set_in(1, 8, 0, 0, 1, 0); tick();
    chk("stall1_m2r", {31'd0, bus.mem_to_reg_e}, 32'd1);
    tick();
    chk("stall2_m2r", {31'd0, bus.mem_to_reg_e}, 32'd1);
    set_in(1, 8, 0, 0, 1, 1); tick();
    chk("flush_valid", {31'd0, bus.valid_e}, 32'd0);

    // beq then disabled bne
    set_in(1, 4, 0, 0, 0, 0); #1;
    chk("beq_branch_d", {31'd0, bus.branch_d}, 32'd1);
    tick();
    set_in(1, 5, 0, 0, 0, 0); #1;
    chk("bne_illegal_d", {31'd0, bus.illegal_d}, 32'd1);
    tick();
    chk("bne_cnt", {24'd0, bus.illegal_cnt}, 32'd1);

    // randomized traffic, never the halt opcode
    for (int i = 0; i < 250; i++) begin
      op = ($urandom_range(0, 9) < 7) ? legal_ops[$urandom_range(0, 10)] : int'($urandom_range(0, 63));
      if (op == HALT) op = 63;
      set_in($urandom_range(0, 7) != 0, op, int'($urandom_range(0, 63)), int'($urandom_range(0, 31)),
             $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
      tick();
    end

    // saturation of the illegal counter
    for (int i = 0; i < 300; i++) begin
      set_in(1, 63, 0, 0, 0, 0); tick();
    end
    chk("cnt_sat", {24'd0, bus.illegal_cnt}, 32'd255);

    set_in(1, 15, 0, 0, 0, 0); tick();
    chk("lui_alucon", {26'd0, bus.alucon_e}, 32'd15);
    chk("lui_shamt", {27'd0, bus.shamt_e}, 32'd16);

    // halt and drain; addi during drain is ignored
    set_in(1, HALT, 0, 0, 0, 0); tick();
    chk("halt_fetch_stop", {31'd0, bus.fetch_stop}, 32'd1);
    set_in(1, 8, 0, 0, 0, 0);
    tick(); tick(); tick();
    chk("halt_not_yet", {31'd0, bus.halted}, 32'd0);
    tick();
    chk("halted_at_5", {31'd0, bus.halted}, 32'd1);
    tick(); tick();
    chk("halted_sticky", {31'd0, bus.halted}, 32'd1);

    // reset in the middle of a drain
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    set_in(1, HALT, 0, 0, 0, 0); tick();
    set_in(1, 8, 0, 0, 0, 0); tick(); tick();
    rst_n = 1'b0; tick();
    chk("rst_fetch_stop", {31'd0, bus.fetch_stop}, 32'd0);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    chk("rst_cnt", {24'd0, bus.illegal_cnt}, 32'd0);
    rst_n = 1'b1;
    set_in(1, 0, 37, 5, 0, 0); tick();
    chk("post_rst_valid", {31'd0, bus.valid_e}, 32'd1);
    set_in(0, 0, 0, 0, 0, 0); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
